uram_pipelined_sdp: RTL and testbench
=====================================

# uram_pipelined_sdp

Parametrised simple-dual-port UltraRAM wrapper. It succeeds the fixed single-cycle RAM with four additions: a configurable read pipeline depth, a read enable with a matching valid flag, per-byte write masks, and a selectable read/write collision mode. An optional hardware clear sequencer zeroes the whole array after reset, so processor register files and scratchpads start from a known state without host-side initialisation. The block sits wherever a core needs a large, deeply pipelined, timing-friendly memory.

## Interface

- DATA_WIDTH, 64, word width in bits; must be a multiple of 8
- ADDRESS_WIDTH, 12, address bits; depth is 2^ADDRESS_WIDTH words
- READ_LATENCY, 2, number of clock edges from read request to data, legal range 1..4
- WRITE_MODE, 0, same-address collision policy: 0 = read_first, 1 = write_first
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset, 0 = skip the clear

- clock  in  1  the single clock; all logic is rising-edge
- reset_n  in  1  asynchronous, active-low reset
- ready  out  1  memory is accepting requests (state RUN)
- ren  in  1  read request
- raddr  in  ADDRESS_WIDTH  read address
- rvalid  out  1  dout carries the data for a read request
- dout  out  DATA_WIDTH  read data
- wen  in  1  write request
- wmask  in  DATA_WIDTH/8  byte enables; bit i covers din[8i+7:8i]
- waddr  in  ADDRESS_WIDTH  write address
- din  in  DATA_WIDTH  write data

## Operation

- FSM states: CLEAR and RUN.
- Reset (reset_n low, asynchronous):
  - state goes to CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - The clear counter goes to 0.
  - The read valid/data pipeline is flushed: rvalid=0, dout=0.
  - ready=0 if CLEAR_ON_RESET=1, else ready=1.
  - Array contents are not affected by reset itself.
- CLEAR:
  - Each cycle, writes all-zero to the address held in the clear counter, then increments the counter.
  - After the edge that writes address 2^ADDRESS_WIDTH-1, the FSM moves to RUN and ready rises.
  - The clear takes exactly 2^ADDRESS_WIDTH cycles.
  - ren, wen, wmask, waddr and din are ignored during CLEAR. No write happens and rvalid stays 0.
  - Asserting reset mid-clear restarts the clear from address 0.
- RUN:
  - Write: at an edge with wen=1, every byte i with wmask[i]=1 of mem[waddr] takes the matching byte of din. Unmasked bytes are unchanged. wen=1 with wmask=0 is a no-op.
  - Read: at an edge with ren=1, mem[raddr] is captured into pipeline stage 1. The captured value moves through READ_LATENCY-1 further registers.
  - A valid bit travels alongside the data in the same pipeline.
  - Reads are fully pipelined: a new read can be issued every cycle, and back-to-back results come out on consecutive cycles.
  - Collision (ren and wen both high, raddr==waddr, same edge):
    - WRITE_MODE=0 returns the old word.
    - WRITE_MODE=1 returns the merged word: masked bytes from din, all other bytes from the old word.
  - Writes after the capture edge never change data already in the pipeline.
  - When no valid data is presented (rvalid=0), dout holds its last value.
- Address arithmetic: the clear counter is ADDRESS_WIDTH+1 bits wide. Its MSB marks completion. It never wraps into RUN early.

## Timing

- Read latency: ren sampled at edge T gives rvalid=1 and valid dout for exactly the cycle after edge T+READ_LATENCY-1. With READ_LATENCY=1, data appears in the cycle immediately after edge T.
- Write latency: data written at edge T is visible to a read sampled at edge T+1. At edge T itself the collision rule applies.
- ready:
  - Rises in the cycle after the final clear edge, and stays high until the next reset.
  - Requests are honoured only when presented at an edge where ready=1.
- All outputs are driven from registers (ready, rvalid, dout). There are no combinational paths from inputs to outputs.
- The last stage of the read pipeline is placed to be absorbed into the URAM output register, and the earlier stages into the cascade registers.

## Test plan

- Reset, then idle with CLEAR_ON_RESET=1 and ADDRESS_WIDTH=4 -> ready=0 for 16 cycles, then 1. Reading all 16 addresses returns 0 with rvalid=1.
- Reset pulsed at clear count 7, then released -> ready rises exactly 16 cycles after release. Address 5, if written before the reset, reads back 0.
- READ_LATENCY=3: write 0xDEADBEEF_CAFEF00D to address 3, then read it with ren held for a single cycle -> rvalid is a single-cycle pulse 3 edges later with that data. dout holds the value afterwards.
- Byte mask: address 9 holds 0x1111111111111111. Write din=0xFFFFFFFFFFFFFFFF with wmask=0x0F -> a read returns 0x11111111FFFFFFFF.
- Collision at address 2 (old 0xAA..AA, din 0x55..55, wmask=0xFF): WRITE_MODE=0 -> read returns 0xAA..AA, WRITE_MODE=1 -> returns 0x55..55. A read at the next edge returns 0x55..55 in both modes.
- Streaming: reads to addresses 0..7 on 8 consecutive edges while address 4 is written at the 2nd edge -> 8 consecutive rvalid cycles in order. Address 4 returns the new data because it was captured after the write.

Source files
------------

// File: rtl/uram_pipelined_sdp_if.sv
// Request/response bundle for the pipelined simple-dual-port URAM wrapper.
// The memory is the slave; the client driving requests is the master.
interface uram_pipelined_sdp_if #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDRESS_WIDTH = 12
);
  logic                      ready;
  logic                      ren;
  logic [ADDRESS_WIDTH-1:0]  raddr;
  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     dout;
  logic                      wen;
  logic [DATA_WIDTH/8-1:0]   wmask;
  logic [ADDRESS_WIDTH-1:0]  waddr;
  logic [DATA_WIDTH-1:0]     din;

  modport master (
    input  ready, rvalid, dout,
    output ren, raddr, wen, wmask, waddr, din
  );

  modport slave (
    output ready, rvalid, dout,
    input  ren, raddr, wen, wmask, waddr, din
  );
endinterface

// File: rtl/uram_pipelined_sdp.sv
// Simple-dual-port UltraRAM wrapper: byte-masked writes, READ_LATENCY-deep
// read pipeline with a travelling valid bit, selectable collision policy and
// an optional post-reset clear of the whole array.
module uram_pipelined_sdp #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDRESS_WIDTH  = 12,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  uram_pipelined_sdp_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam int unsigned NBYTE = DATA_WIDTH / 8;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ADDRESS_WIDTH:0]    r_clr_cnt;
  logic [ADDRESS_WIDTH:0]    w_clr_cnt_nxt;

  logic                      w_clearing;
  logic                      w_rd_go;
  logic                      w_wr_go;
  logic                      w_collide;

  logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]     w_rd_old;
  logic [DATA_WIDTH-1:0]     w_rd_word;

  logic [DATA_WIDTH-1:0]     r_pipe_d [READ_LATENCY];
  logic [READ_LATENCY-1:0]   r_pipe_v;

  assign w_clearing = (r_state == S_CLEAR);
  assign w_rd_go    = bus.ren & (r_state == S_RUN);
  assign w_wr_go    = bus.wen & (r_state == S_RUN);
  assign w_collide  = w_rd_go & w_wr_go & (bus.raddr == bus.waddr);

  // State and clear-counter registers; reset restarts the clear from address 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= RESET_STATE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Next-state: the counter's carry into the MSB marks the final clear write
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + (ADDRESS_WIDTH+1)'(1);
        if (w_clr_cnt_nxt[ADDRESS_WIDTH]) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // Array write port: clear sequencer owns the port while clearing
  always_ff @(posedge clock) begin
    if (w_clearing) begin
      r_mem[r_clr_cnt[ADDRESS_WIDTH-1:0]] <= '0;
    end else if (w_wr_go) begin
      for (int unsigned b = 0; b < NBYTE; b++) begin
        if (bus.wmask[b]) begin
          r_mem[bus.waddr][8*b +: 8] <= bus.din[8*b +: 8];
        end
      end
    end
  end

  assign w_rd_old = r_mem[bus.raddr];

  // Read word selection: write_first merges the masked din bytes on collision
  always_comb begin
    w_rd_word = w_rd_old;
    if ((WRITE_MODE == 1) && w_collide) begin
      for (int unsigned b = 0; b < NBYTE; b++) begin
        if (bus.wmask[b]) begin
          w_rd_word[8*b +: 8] = bus.din[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline: data stages load only behind a valid bit so dout holds between reads
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe_v <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_pipe_d[i] <= '0;
      end
    end else begin
      r_pipe_v[0] <= w_rd_go;
      if (w_rd_go) begin
        r_pipe_d[0] <= w_rd_word;
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        if (r_pipe_v[i-1]) begin
          r_pipe_d[i] <= r_pipe_d[i-1];
        end
      end
    end
  end

  assign bus.ready  = (r_state == S_RUN);
  assign bus.rvalid = r_pipe_v[READ_LATENCY-1];
  assign bus.dout   = r_pipe_d[READ_LATENCY-1];

endmodule

// File: tb/tb_uram_pipelined_sdp.sv
// Directed bench: two wrappers (read_first and write_first) with a 16-word
// array and three-stage read pipeline, driven by identical stimulus.
module tb_uram_pipelined_sdp;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 4;
  localparam int unsigned RL = 3;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  uram_pipelined_sdp_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) b0 ();
  uram_pipelined_sdp_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) b1 ();

  uram_pipelined_sdp #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL),
    .WRITE_MODE(0), .CLEAR_ON_RESET(1)
  ) u_rf (
    .clock(clock), .reset_n(reset_n), .bus(b0.slave)
  );

  uram_pipelined_sdp #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL),
    .WRITE_MODE(1), .CLEAR_ON_RESET(1)
  ) u_wf (
    .clock(clock), .reset_n(reset_n), .bus(b1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic ren, input logic [AW-1:0] raddr,
                     input logic wen, input logic [AW-1:0] waddr,
                     input logic [DW-1:0] din, input logic [DW/8-1:0] wmask);
    b0.ren = ren; b0.raddr = raddr; b0.wen = wen; b0.waddr = waddr; b0.din = din; b0.wmask = wmask;
    b1.ren = ren; b1.raddr = raddr; b1.wen = wen; b1.waddr = waddr; b1.din = din; b1.wmask = wmask;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    chk({tag, "_rdy_rf"}, DW'(b0.ready), DW'(exp));
    chk({tag, "_rdy_wf"}, DW'(b1.ready), DW'(exp));
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [DW-1:0] d_rf, input logic [DW-1:0] d_wf);
    chk({tag, "_vld_rf"}, DW'(b0.rvalid), DW'(v));
    chk({tag, "_vld_wf"}, DW'(b1.rvalid), DW'(v));
    chk({tag, "_dat_rf"}, b0.dout, d_rf);
    chk({tag, "_dat_wf"}, b1.dout, d_wf);
  endtask

  task automatic chk_nv(input string tag);
    chk({tag, "_vld_rf"}, DW'(b0.rvalid), '0);
    chk({tag, "_vld_wf"}, DW'(b1.rvalid), '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] m);
    drv(1'b0, '0, 1'b1, a, d, m);
    tick();
    drv(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a,
                    input logic [DW-1:0] e_rf, input logic [DW-1:0] e_wf);
    drv(1'b1, a, 1'b0, '0, '0, '0);
    tick();
    drv(1'b0, '0, 1'b0, '0, '0, '0);
    tick();
    tick();
    chk_out(tag, 1'b1, e_rf, e_wf);
  endtask

  logic [DW-1:0] exp_s [8];
  logic [DW-1:0] pat;

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    drv(1'b0, '0, 1'b0, '0, '0, '0);
    tick();
    tick();
    chk_rdy("rst", 1'b0);
    chk_out("rst", 1'b0, '0, '0);

    // Release reset; requests presented during the clear must be ignored
    reset_n = 1'b1;
    drv(1'b1, 4'd0, 1'b1, 4'd0, '1, '1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk_rdy($sformatf("clr_k%0d", k), (k == 16));
      chk_nv($sformatf("clr_k%0d", k));
      if (k == 15) drv(1'b0, '0, 1'b0, '0, '0, '0);
    end

    // Whole array reads back zero, streamed
    for (int c = 0; c < 18; c++) begin
      if (c < 16) drv(1'b1, AW'(c), 1'b0, '0, '0, '0);
      else        drv(1'b0, '0, 1'b0, '0, '0, '0);
      tick();
      if (c >= 2) chk_out($sformatf("zero_a%0d", c - 2), 1'b1, '0, '0);
      else        chk_nv($sformatf("zero_c%0d", c));
    end
    tick();
    chk_nv("zero_end");

    // Latency: single-cycle read pulse, valid 3 edges later, then held
    pat = 64'hDEADBEEF_CAFEF00D;
    wr(4'd3, pat, 8'hFF);
    drv(1'b1, 4'd3, 1'b0, '0, '0, '0);
    tick();
    drv(1'b0, '0, 1'b0, '0, '0, '0);
    chk_nv("lat_e0");
    tick();
    chk_nv("lat_e1");
    tick();
    chk_out("lat_e2", 1'b1, pat, pat);
    tick();
    chk_out("lat_e3", 1'b0, pat, pat);
    tick();
    chk_out("lat_e4", 1'b0, pat, pat);

    // Byte masks
    wr(4'd9, 64'h1111111111111111, 8'hFF);
    wr(4'd9, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    rd("mask_lo", 4'd9, 64'h11111111FFFFFFFF, 64'h11111111FFFFFFFF);
    wr(4'd9, 64'h0000000000000000, 8'h00);
    rd("mask_none", 4'd9, 64'h11111111FFFFFFFF, 64'h11111111FFFFFFFF);
    wr(4'd9, 64'hAB00000000000000, 8'h80);
    rd("mask_hi", 4'd9, 64'hAB111111FFFFFFFF, 64'hAB111111FFFFFFFF);

    // Collision, full mask
    wr(4'd2, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    drv(1'b1, 4'd2, 1'b1, 4'd2, 64'h5555555555555555, 8'hFF);
    tick();
    drv(1'b1, 4'd2, 1'b0, '0, '0, '0);
    tick();
    drv(1'b0, '0, 1'b0, '0, '0, '0);
    tick();
    chk_out("col_same", 1'b1, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555);
    tick();
    chk_out("col_next", 1'b1, 64'h5555555555555555, 64'h5555555555555555);

    // Collision, partial mask: write_first merges with the old word
    drv(1'b1, 4'd2, 1'b1, 4'd2, 64'h0123456789ABCDEF, 8'h0F);
    tick();
    drv(1'b0, '0, 1'b0, '0, '0, '0);
    tick();
    tick();
    chk_out("colp_same", 1'b1, 64'h5555555555555555, 64'h5555555589ABCDEF);
    rd("colp_after", 4'd2, 64'h5555555589ABCDEF, 64'h5555555589ABCDEF);

    // Streaming reads 0..7 with address 4 rewritten at the 2nd edge
    for (int a = 0; a < 8; a++) begin
      exp_s[a] = {8{8'(a)}};
      wr(AW'(a), exp_s[a], 8'hFF);
    end
    exp_s[4] = 64'hCCCCCCCCCCCCCCCC;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) drv(1'b1, AW'(c), (c == 1), 4'd4, 64'hCCCCCCCCCCCCCCCC, 8'hFF);
      else       drv(1'b0, '0, 1'b0, '0, '0, '0);
      tick();
      if (c >= 2) chk_out($sformatf("strm_a%0d", c - 2), 1'b1, exp_s[c-2], exp_s[c-2]);
      else        chk_nv($sformatf("strm_c%0d", c));
    end
    tick();
    chk_nv("strm_end");

    // Reset pulsed mid-clear restarts the clear from address 0
    wr(4'd5, 64'h5A5A5A5A5A5A5A5A, 8'hFF);
    rd("pre_rst5", 4'd5, 64'h5A5A5A5A5A5A5A5A, 64'h5A5A5A5A5A5A5A5A);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    chk_rdy("midclr_run", 1'b0);
    reset_n = 1'b0;
    #1;
    chk_rdy("midclr_rst", 1'b0);
    chk_out("midclr_rst", 1'b0, '0, '0);
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk_rdy($sformatf("reclr_k%0d", k), (k == 16));
    end
    rd("reclr_a5", 4'd5, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
